// File: rtl/psk_pkg.sv
// Shared constants, configuration payload and scheduler state encoding for the PSK modem.
package psk_pkg;

    localparam logic [3:0]  MODE_BPSK    = 4'b0001;
    localparam logic [3:0]  MODE_QPSK    = 4'b0010;
    localparam logic [3:0]  MODE_MIX     = 4'b0100;

    localparam logic [15:0] PHASE_RST    = 16'd8190;
    localparam logic [3:0]  DELAY_RST    = 4'd8;
    localparam logic [3:0]  GARDNER_RST  = 4'd3;
    localparam logic [3:0]  FEEDBACK_RST = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        SETTLE
    } sched_state_e;

    // One complete datapath configuration as applied to the modem.
    typedef struct packed {
        logic [3:0]  mode;
        logic [15:0] phase;
        logic [3:0]  delay;
        logic [3:0]  gardner_shift;
        logic [3:0]  feedback_shift;
    } sched_cfg_t;

    localparam sched_cfg_t CFG_RST = '{
        mode:           MODE_BPSK,
        phase:          PHASE_RST,
        delay:          DELAY_RST,
        gardner_shift:  GARDNER_RST,
        feedback_shift: FEEDBACK_RST
    };

    function automatic logic mode_legal(input logic [3:0] mode);
        return (mode == MODE_BPSK) || (mode == MODE_QPSK) || (mode == MODE_MIX);
    endfunction

endpackage

// File: rtl/psk_sched_timer.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
module psk_sched_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/psk_mode_sched.sv
// Mode/config scheduler: drains the in-flight Tx frame, applies the new config, flushes Rx, settles.
// Optional DRAIN timeout is compiled in with PSK_SCHED_TIMEOUT_EN.
module psk_mode_sched
    import psk_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES  = 64
`ifdef PSK_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic        clk_1M024,
    input  logic        rst_n_1M024,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_mode,
    input  logic [15:0] cfg_phase,
    input  logic [3:0]  cfg_delay,
    input  logic [3:0]  cfg_gardner_shift,
    input  logic [3:0]  cfg_feedback_shift,
    input  logic        tx_tvalid,
    input  logic        tx_tlast,
    output logic [3:0]  MODE_CTRL,
    output logic [15:0] TX_PHASE_CONFIG,
    output logic [3:0]  DELAY_CNT,
    output logic [3:0]  GARDNER_SHIFT,
    output logic [3:0]  FEEDBACK_SHIFT,
    output logic        tx_hold,
    output logic        rx_flush,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        drain_timeout
);

    localparam int unsigned FS_MAX  = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
`ifdef PSK_SCHED_TIMEOUT_EN
    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > FS_MAX) ? TIMEOUT_CYCLES : FS_MAX;
`else
    localparam int unsigned TMR_MAX = FS_MAX;
`endif
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    sched_state_e state;
    sched_state_e next_state;

    sched_cfg_t   req;
    sched_cfg_t   shadow;
    sched_cfg_t   applied;
    logic         req_legal;
    logic         in_frame;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero_c;

    logic         latch;
    logic         apply;
    logic         done_nxt;
    logic         err_nxt;
`ifdef PSK_SCHED_TIMEOUT_EN
    logic         drain_force;
`endif

    assign req = '{
        mode:           cfg_mode,
        phase:          cfg_phase,
        delay:          cfg_delay,
        gardner_shift:  cfg_gardner_shift,
        feedback_shift: cfg_feedback_shift
    };
    assign req_legal = mode_legal(cfg_mode) && (cfg_phase != 16'd0);

    psk_sched_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk_1M024),
        .rst_n    (rst_n_1M024),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk_1M024) begin
        if (!rst_n_1M024) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Timer is loaded on entry to each timed state; zero means the state's budget is spent.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        latch      = 1'b0;
        apply      = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
`ifdef PSK_SCHED_TIMEOUT_EN
        drain_force = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    if (!req_legal) begin
                        err_nxt = 1'b1;
                    end else if (req == applied) begin
                        done_nxt = 1'b1;
                    end else begin
                        latch      = 1'b1;
                        next_state = DRAIN;
`ifdef PSK_SCHED_TIMEOUT_EN
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
            end
            DRAIN: begin
                if (!in_frame || (tx_tvalid && tx_tlast)) begin
                    next_state = FLUSH;
                    apply      = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(FLUSH_CYCLES - 1);
                end
`ifdef PSK_SCHED_TIMEOUT_EN
                else if (tmr_zero_c) begin
                    drain_force = 1'b1;
                    next_state  = FLUSH;
                    apply       = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = TMR_W'(FLUSH_CYCLES - 1);
                end
`endif
            end
            FLUSH: begin
                if (tmr_zero_c) begin
                    next_state = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (tmr_zero_c) begin
                    next_state = IDLE;
                    done_nxt   = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A forced drain abandons the tracked frame so the next DRAIN does not stall on it.
    always_ff @(posedge clk_1M024) begin
        if (!rst_n_1M024) begin
            in_frame <= 1'b0;
`ifdef PSK_SCHED_TIMEOUT_EN
        end else if (drain_force) begin
            in_frame <= 1'b0;
`endif
        end else if (tx_tvalid) begin
            in_frame <= ~tx_tlast;
        end
    end

    always_ff @(posedge clk_1M024) begin
        if (!rst_n_1M024) begin
            shadow    <= CFG_RST;
            applied   <= CFG_RST;
            tx_hold   <= 1'b0;
            rx_flush  <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (latch) begin
                shadow <= req;
            end
            if (apply) begin
                applied <= shadow;
            end
            tx_hold   <= (next_state != IDLE);
            rx_flush  <= (next_state == FLUSH);
            busy      <= (next_state != IDLE);
            cfg_ready <= (next_state == IDLE);
            cfg_done  <= done_nxt;
            cfg_err   <= err_nxt;
        end
    end

`ifdef PSK_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_1M024) begin
        if (!rst_n_1M024) begin
            drain_timeout <= 1'b0;
        end else if (latch) begin
            drain_timeout <= 1'b0;
        end else if (drain_force) begin
            drain_timeout <= 1'b1;
        end
    end
`else
    assign drain_timeout = 1'b0;
`endif

    assign MODE_CTRL       = applied.mode;
    assign TX_PHASE_CONFIG = applied.phase;
    assign DELAY_CNT       = applied.delay;
    assign GARDNER_SHIFT   = applied.gardner_shift;
    assign FEEDBACK_SHIFT  = applied.feedback_shift;

endmodule

// File: tb/tb_psk_mode_sched.sv
// Directed bench for psk_mode_sched: idle/mid-frame requests, illegal and redundant requests, reset, timeout.
module tb_psk_mode_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_mode;
    logic [15:0] cfg_phase;
    logic [3:0]  cfg_delay;
    logic [3:0]  cfg_gardner_shift;
    logic [3:0]  cfg_feedback_shift;
    logic        tx_tvalid;
    logic        tx_tlast;
    logic [3:0]  mode_ctrl;
    logic [15:0] tx_phase_config;
    logic [3:0]  delay_cnt;
    logic [3:0]  gardner_shift;
    logic [3:0]  feedback_shift;
    logic        tx_hold;
    logic        rx_flush;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        drain_timeout;

    int n_chk = 0;
    int n_bad = 0;
    int cnt;

    always #5 clk = ~clk;

    psk_mode_sched dut (
        .clk_1M024          (clk),
        .rst_n_1M024        (rst_n),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_mode           (cfg_mode),
        .cfg_phase          (cfg_phase),
        .cfg_delay          (cfg_delay),
        .cfg_gardner_shift  (cfg_gardner_shift),
        .cfg_feedback_shift (cfg_feedback_shift),
        .tx_tvalid          (tx_tvalid),
        .tx_tlast           (tx_tlast),
        .MODE_CTRL          (mode_ctrl),
        .TX_PHASE_CONFIG    (tx_phase_config),
        .DELAY_CNT          (delay_cnt),
        .GARDNER_SHIFT      (gardner_shift),
        .FEEDBACK_SHIFT     (feedback_shift),
        .tx_hold            (tx_hold),
        .rx_flush           (rx_flush),
        .busy               (busy),
        .cfg_done           (cfg_done),
        .cfg_err            (cfg_err),
        .drain_timeout      (drain_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_req(input logic [3:0] m, input logic [15:0] p, input logic [3:0] d,
                             input logic [3:0] g, input logic [3:0] f);
        cfg_mode           = m;
        cfg_phase          = p;
        cfg_delay          = d;
        cfg_gardner_shift  = g;
        cfg_feedback_shift = f;
        cfg_valid          = 1'b1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!cfg_done && cycles < 5000) begin
            tick(1);
            cycles++;
        end
    endtask

    task automatic check_cfg(input string pfx, input logic [3:0] m, input logic [15:0] p,
                             input logic [3:0] d, input logic [3:0] g, input logic [3:0] f);
        check_eq({pfx, "_mode"},  32'(mode_ctrl),       32'(m));
        check_eq({pfx, "_phase"}, 32'(tx_phase_config), 32'(p));
        check_eq({pfx, "_delay"}, 32'(delay_cnt),       32'(d));
        check_eq({pfx, "_gshift"}, 32'(gardner_shift),  32'(g));
        check_eq({pfx, "_fshift"}, 32'(feedback_shift), 32'(f));
    endtask

    initial begin
        rst_n              = 1'b0;
        cfg_valid          = 1'b0;
        cfg_mode           = 4'd0;
        cfg_phase          = 16'd0;
        cfg_delay          = 4'd0;
        cfg_gardner_shift  = 4'd0;
        cfg_feedback_shift = 4'd0;
        tx_tvalid          = 1'b0;
        tx_tlast           = 1'b0;

        // reset values
        tick(3);
        check_cfg("rst", 4'b0001, 16'd8190, 4'd8, 4'd3, 4'd0);
        check_eq("rst_ready", 32'(cfg_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_hold", 32'(tx_hold), 32'd0);
        check_eq("rst_flush", 32'(rx_flush), 32'd0);
        check_eq("rst_tmo", 32'(drain_timeout), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check_eq("rel_ready", 32'(cfg_ready), 32'd1);

        // idle request: QPSK, no traffic
        drive_req(4'b0010, 16'd8192, 4'd8, 4'd3, 4'd0);
        tick(1);
        cfg_valid = 1'b0;
        check_eq("idle_busy_n1", 32'(busy), 32'd1);
        check_eq("idle_hold_n1", 32'(tx_hold), 32'd1);
        check_eq("idle_mode_n1", 32'(mode_ctrl), 32'b0001);
        check_eq("idle_flush_n1", 32'(rx_flush), 32'd0);
        tick(1);
        check_eq("idle_mode_n2", 32'(mode_ctrl), 32'b0010);
        check_eq("idle_phase_n2", 32'(tx_phase_config), 32'd8192);
        check_eq("idle_flush_n2", 32'(rx_flush), 32'd1);
        cnt = 0;
        while (rx_flush && cnt < 100) begin
            cnt++;
            tick(1);
        end
        check_eq("idle_flush_len", 32'(cnt), 32'd16);
        check_eq("idle_hold_settle", 32'(tx_hold), 32'd1);
        wait_done(cnt);
        check_eq("idle_settle_len", 32'(cnt), 32'd64);
        check_eq("idle_hold_done", 32'(tx_hold), 32'd0);
        check_eq("idle_busy_done", 32'(busy), 32'd0);
        check_eq("idle_ready_done", 32'(cfg_ready), 32'd1);
        tick(1);
        check_eq("idle_done_pulse", 32'(cfg_done), 32'd0);

        // illegal mode
        drive_req(4'b0011, 16'd100, 4'd8, 4'd3, 4'd0);
        tick(1);
        cfg_valid = 1'b0;
        check_eq("ill_mode_err", 32'(cfg_err), 32'd1);
        check_eq("ill_mode_busy", 32'(busy), 32'd0);
        check_eq("ill_mode_mode", 32'(mode_ctrl), 32'b0010);
        tick(1);
        check_eq("ill_mode_err_pulse", 32'(cfg_err), 32'd0);
        check_eq("ill_mode_hold", 32'(tx_hold), 32'd0);

        // illegal zero phase
        drive_req(4'b0001, 16'd0, 4'd8, 4'd3, 4'd0);
        tick(1);
        cfg_valid = 1'b0;
        check_eq("ill_phase_err", 32'(cfg_err), 32'd1);
        check_eq("ill_phase_busy", 32'(busy), 32'd0);
        check_eq("ill_phase_mode", 32'(mode_ctrl), 32'b0010);
        check_eq("ill_phase_phase", 32'(tx_phase_config), 32'd8192);
        tick(1);

        // redundant request equal to applied values
        drive_req(4'b0010, 16'd8192, 4'd8, 4'd3, 4'd0);
        tick(1);
        cfg_valid = 1'b0;
        check_eq("red_done", 32'(cfg_done), 32'd1);
        check_eq("red_busy", 32'(busy), 32'd0);
        check_eq("red_hold", 32'(tx_hold), 32'd0);
        tick(1);
        check_eq("red_flush", 32'(rx_flush), 32'd0);
        check_eq("red_done_pulse", 32'(cfg_done), 32'd0);

        // mid-frame request: MIX after byte 3 of a 10-byte frame
        for (int b = 0; b < 10; b++) begin
            tx_tvalid = 1'b1;
            tx_tlast  = (b == 9);
            if (b == 3) drive_req(4'b0100, 16'd1000, 4'd5, 4'd2, 4'd1);
            else        cfg_valid = 1'b0;
            tick(1);
            if (b >= 3 && b < 9) begin
                check_eq($sformatf("mf_mode_b%0d", b), 32'(mode_ctrl), 32'b0010);
                check_eq($sformatf("mf_flush_b%0d", b), 32'(rx_flush), 32'd0);
                check_eq($sformatf("mf_hold_b%0d", b), 32'(tx_hold), 32'd1);
            end
        end
        tx_tvalid = 1'b0;
        tx_tlast  = 1'b0;
        cfg_valid = 1'b0;
        check_cfg("mf_apply", 4'b0100, 16'd1000, 4'd5, 4'd2, 4'd1);
        check_eq("mf_flush_rise", 32'(rx_flush), 32'd1);
        wait_done(cnt);
        check_eq("mf_done_lat", 32'(cnt), 32'd80);
        check_eq("mf_hold_done", 32'(tx_hold), 32'd0);
        check_eq("mf_tmo", 32'(drain_timeout), 32'd0);
        tick(1);

        // reset in the middle of FLUSH
        drive_req(4'b0001, 16'd500, 4'd8, 4'd3, 4'd0);
        tick(1);
        cfg_valid = 1'b0;
        tick(1);
        check_eq("rf_flush_on", 32'(rx_flush), 32'd1);
        check_eq("rf_mode_on", 32'(mode_ctrl), 32'b0001);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check_cfg("rf", 4'b0001, 16'd8190, 4'd8, 4'd3, 4'd0);
        check_eq("rf_flush", 32'(rx_flush), 32'd0);
        check_eq("rf_hold", 32'(tx_hold), 32'd0);
        check_eq("rf_busy", 32'(busy), 32'd0);
        check_eq("rf_ready_low", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check_eq("rf_ready_rel", 32'(cfg_ready), 32'd1);

        // redundant request equal to reset defaults
        drive_req(4'b0001, 16'd8190, 4'd8, 4'd3, 4'd0);
        tick(1);
        cfg_valid = 1'b0;
        check_eq("def_done", 32'(cfg_done), 32'd1);
        check_eq("def_hold", 32'(tx_hold), 32'd0);
        check_eq("def_busy", 32'(busy), 32'd0);
        tick(1);
        check_eq("def_flush", 32'(rx_flush), 32'd0);
        check_eq("def_hold2", 32'(tx_hold), 32'd0);

`ifdef PSK_SCHED_TIMEOUT_EN
        // endless frame forces FLUSH after the DRAIN budget
        tx_tvalid = 1'b1;
        tx_tlast  = 1'b0;
        tick(2);
        drive_req(4'b0010, 16'd8192, 4'd8, 4'd3, 4'd0);
        tick(1);
        cfg_valid = 1'b0;
        cnt = 0;
        while (!rx_flush && cnt < 5000) begin
            tick(1);
            cnt++;
        end
        tx_tvalid = 1'b0;
        check_eq("tmo_drain_len", 32'(cnt), 32'd4096);
        check_eq("tmo_flag", 32'(drain_timeout), 32'd1);
        check_eq("tmo_mode", 32'(mode_ctrl), 32'b0010);
        wait_done(cnt);
        check_eq("tmo_done_lat", 32'(cnt), 32'd80);
        check_eq("tmo_flag_kept", 32'(drain_timeout), 32'd1);
        tick(1);
        drive_req(4'b0100, 16'd1000, 4'd5, 4'd2, 4'd1);
        tick(1);
        cfg_valid = 1'b0;
        check_eq("tmo_flag_clr", 32'(drain_timeout), 32'd0);
        wait_done(cnt);
        check_eq("tmo_next_lat", 32'(cnt), 32'd81);
        check_eq("tmo_next_mode", 32'(mode_ctrl), 32'b0100);
`else
        check_eq("notmo_flag", 32'(drain_timeout), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/psk_mode_sched.md
# psk_mode_sched

Mode and configuration scheduler for the PSK modem. It accepts a requested modulation mode and datapath configuration and holds the Tx source off new frames. It waits for the in-flight Tx frame to finish, then applies the new MODE_CTRL and the Tx/Rx tuning values. Finally it flushes the Rx datapath and waits a settle period before releasing Tx, so mode changes never land mid-frame.

## Interface
- FLUSH_CYCLES, 16: cycles rx_flush is held high.
- SETTLE_CYCLES, 64: cycles after flush before Tx is released.
- TIMEOUT_CYCLES, 4096: maximum DRAIN duration, used only when the timeout feature is compiled in.
- clk_1M024  in  1: block clock.
- rst_n_1M024  in  1: synchronous, active-low reset.
- cfg_valid  in  1: a configuration request is present.
- cfg_ready  out  1: the block can accept a request.
- cfg_mode  in  4: requested mode; legal values are BPSK 4'b0001, QPSK 4'b0010, MIX 4'b0100.
- cfg_phase  in  16: requested TX_PHASE_CONFIG; must be nonzero.
- cfg_delay  in  4: requested DELAY_CNT.
- cfg_gardner_shift  in  4: requested GARDNER_SHIFT.
- cfg_feedback_shift  in  4: requested FEEDBACK_SHIFT.
- tx_tvalid  in  1: Tx byte-stream valid, monitored only.
- tx_tlast  in  1: Tx byte-stream last, monitored only.
- MODE_CTRL  out  4: applied mode.
- TX_PHASE_CONFIG  out  16: applied NCO phase step.
- DELAY_CNT  out  4: applied Tx delay.
- GARDNER_SHIFT  out  4: applied Gardner loop shift.
- FEEDBACK_SHIFT  out  4: applied carrier-loop shift.
- tx_hold  out  1: the Tx source must not start a new frame while this is high.
- rx_flush  out  1: active-high reset to the Rx datapath.
- busy  out  1: the block is not in IDLE.
- cfg_done  out  1: one-cycle pulse when a request completes.
- cfg_err  out  1: one-cycle pulse when a request is rejected.
- drain_timeout  out  1: sticky flag set when DRAIN is forced.

## Operation
- The state machine has four states: IDLE, DRAIN, FLUSH, SETTLE.
- Frame tracking uses an internal in_frame flag, updated every cycle.
  - Set on tx_tvalid & ~tx_tlast.
  - Cleared on tx_tvalid & tx_tlast.
  - Reset value is 0.
- IDLE:
  - cfg_ready = 1.
  - A request is accepted on cfg_valid & cfg_ready.
  - The legality check happens in the same cycle as acceptance.
  - An illegal request (mode not one of the three legal codes, or cfg_phase == 0) pulses cfg_err the next cycle. State is unchanged and the shadow registers are not written.
  - A legal request that is identical to the applied values pulses cfg_done the next cycle and the block stays in IDLE; no flush occurs.
  - Any other legal request is latched into the shadow registers and the block goes to DRAIN. drain_timeout is cleared at this point.
- DRAIN:
  - tx_hold = 1.
  - Exit to FLUSH when in_frame == 0.
  - Also exit to FLUSH in the cycle tx_tvalid & tx_tlast is sampled.
- FLUSH:
  - On entry, the shadow values are copied to the config outputs.
  - rx_flush = 1 for exactly FLUSH_CYCLES cycles, then the block goes to SETTLE.
- SETTLE:
  - tx_hold = 1 for SETTLE_CYCLES cycles.
  - Then the block goes to IDLE and pulses cfg_done.
- busy = (state != IDLE).
- cfg_ready = (state == IDLE).
- cfg_valid outside IDLE is ignored; the requester must hold it until cfg_ready.
- Reset values:
  - MODE_CTRL = 4'b0001.
  - TX_PHASE_CONFIG = 16'd8190.
  - DELAY_CNT = 4'd8.
  - GARDNER_SHIFT = 4'd3.
  - FEEDBACK_SHIFT = 4'd0.
  - tx_hold, rx_flush, busy, cfg_done, cfg_err and drain_timeout are all 0.
  - cfg_ready is 0 while rst_n_1M024 is low and 1 on the first cycle after release.
- Reset mid-operation aborts to IDLE with all outputs at their reset values. The shadow registers are discarded and rx_flush drops at the reset edge.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Acceptance at edge N: tx_hold = 1 and busy = 1 from N+1.
- DRAIN with in_frame == 0 at acceptance: DRAIN lasts 1 cycle, so the config outputs and rx_flush change at N+2.
- Frame-end at edge M in DRAIN: the config outputs update and rx_flush rises at M+1.
- rx_flush falls after FLUSH_CYCLES cycles.
- tx_hold falls, and cfg_done pulses, SETTLE_CYCLES cycles after rx_flush falls.
- Minimum request-to-done latency is 2 + FLUSH_CYCLES + SETTLE_CYCLES cycles.
- The timer counts down from the loaded value, which is the parameter minus 1, and exits the state at 0.
- Timer width is clog2 of the largest parameter.

## Configuration
- PSK_SCHED_TIMEOUT_EN defined:
  - DRAIN counts cycles.
  - At TIMEOUT_CYCLES cycles without a frame end, the block forces FLUSH, sets drain_timeout, and clears in_frame.
- PSK_SCHED_TIMEOUT_EN not defined:
  - DRAIN waits indefinitely for a frame end.
  - drain_timeout is tied to 0.
  - No timeout counter is synthesized.

## Structure
- Shared package psk_pkg holds:
  - the mode constants MODE_BPSK, MODE_QPSK, MODE_MIX;
  - the reset defaults for phase, delay and the two shifts;
  - the state enum {IDLE, DRAIN, FLUSH, SETTLE}.
- One sub-module, psk_sched_timer: a loadable down-counter with a zero flag, shared by DRAIN (timeout), FLUSH and SETTLE.

## Test plan
- Idle request: release reset, no Tx traffic, request QPSK with phase 8192 → MODE_CTRL = 0010 at N+2, rx_flush high 16 cycles, cfg_done 64 cycles later, tx_hold low afterward.
- Mid-frame request: start a 10-byte Tx frame, request MIX after byte 3 → outputs unchanged until the cycle after the tlast byte, then flush and settle.
- Illegal requests: cfg_mode = 0011 → cfg_err pulse, busy stays 0, MODE_CTRL stays 0001. cfg_phase = 0 → same response.
- Redundant request: a request equal to the reset defaults → cfg_done the next cycle with no rx_flush and no tx_hold.
- Timeout (macro defined): hold tx_tvalid high without tlast, request QPSK → forced FLUSH after 4096 DRAIN cycles and drain_timeout = 1. The next accepted request clears drain_timeout.
- Reset mid-flush: assert rst_n_1M024 low during FLUSH → all outputs return to their reset values on the next edge and cfg_ready = 1 on the first cycle after release.
